// File: rtl/beep_melody_seq.sv
// beep_melody_seq: game-over jingle generator for the buzzer path.
// Plays an 8-entry note ROM once on entry into game-over mode
// (gamemode == 2'b11), producing a registered square-wave beep.
// The FSM state is exported on o_dbg_state for observation.
module beep_melody_seq #(
  parameter int unsigned BEAT_CYCLES = 32'd12_500_000,
  parameter int unsigned GAP_CYCLES  = 32'd1_250_000,
  parameter int unsigned HP_SHIFT    = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gamemode,
  output logic       beep,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Raw half-period (clock cycles) per ROM entry; 0 marks a rest.
  function automatic logic [17:0] rom_hp_raw(input logic [2:0] idx);
    logic [17:0] v;
    case (idx)
      3'd0:    v = 18'd63776;   // G5
      3'd1:    v = 18'd75843;   // E5
      3'd2:    v = 18'd95557;   // C5
      3'd3:    v = 18'd0;       // rest
      3'd4:    v = 18'd151685;  // E4
      3'd5:    v = 18'd127551;  // G4
      3'd6:    v = 18'd191110;  // C4
      default: v = 18'd191110;  // C4 (final, long)
    endcase
    return v;
  endfunction

  // Duration in beats per ROM entry.
  function automatic logic [2:0] rom_beats(input logic [2:0] idx);
    logic [2:0] v;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: v = 3'd1;
      3'd4, 3'd5, 3'd6:       v = 3'd2;
      default:                v = 3'd4;
    endcase
    return v;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_gm_prev;
  logic        r_beep;
  logic        r_busy;
  logic [2:0]  r_note_idx;
  logic [31:0] r_dur_cnt;
  logic [17:0] r_hp_cnt;

  logic        w_beep_nxt;
  logic        w_busy_nxt;
  logic [2:0]  w_idx_nxt;
  logic [31:0] w_dur_nxt;
  logic [17:0] w_hp_nxt;

  logic        w_in_go;
  logic        w_trig;
  logic [17:0] w_cur_hp;
  logic [17:0] w_next_hp;
  logic [17:0] w_first_hp;
  logic [31:0] w_play_len;
  logic        w_play_last;
  logic        w_gap_last;

  assign w_in_go     = (gamemode == 2'b11);
  // Rising into game over only; staying in 2'b11 never retriggers.
  assign w_trig      = w_in_go && (r_gm_prev != 2'b11);
  assign w_cur_hp    = rom_hp_raw(r_note_idx) >> HP_SHIFT;
  assign w_next_hp   = rom_hp_raw(r_note_idx + 3'd1) >> HP_SHIFT;
  assign w_first_hp  = rom_hp_raw(3'd0) >> HP_SHIFT;
  assign w_play_len  = 32'(rom_beats(r_note_idx)) * BEAT_CYCLES;
  assign w_play_last = (r_dur_cnt == w_play_len - 32'd1);
  assign w_gap_last  = (r_dur_cnt == GAP_CYCLES - 32'd1);

  // State register; reset has priority over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: trigger, note/gap sequencing, abort on mode exit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trig) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (!w_in_go)         w_state_nxt = S_IDLE;
        else if (w_play_last) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (!w_in_go) begin
          w_state_nxt = S_IDLE;
        end else if (w_gap_last) begin
          w_state_nxt = (r_note_idx == 3'd7) ? S_DONE : S_PLAY;
        end
      end
      default: begin
        if (!w_in_go) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output / counter next values, keyed on the transition being taken.
  always_comb begin
    w_beep_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    w_idx_nxt  = 3'd0;
    w_dur_nxt  = 32'd0;
    w_hp_nxt   = 18'd0;
    case (w_state_nxt)
      S_IDLE: begin
        // everything cleared
      end
      S_DONE: begin
        w_idx_nxt = 3'd7;
      end
      S_GAP: begin
        w_busy_nxt = 1'b1;
        w_idx_nxt  = r_note_idx;
        if (r_state == S_GAP) w_dur_nxt = r_dur_cnt + 32'd1;
      end
      default: begin  // S_PLAY
        w_busy_nxt = 1'b1;
        if (r_state == S_PLAY) begin
          w_idx_nxt = r_note_idx;
          w_dur_nxt = r_dur_cnt + 32'd1;
          if (w_cur_hp == 18'd0) begin
            w_beep_nxt = 1'b0;
          end else if (r_hp_cnt == w_cur_hp - 18'd1) begin
            w_beep_nxt = ~r_beep;
            w_hp_nxt   = 18'd0;
          end else begin
            w_beep_nxt = r_beep;
            w_hp_nxt   = r_hp_cnt + 18'd1;
          end
        end else if (r_state == S_GAP) begin
          w_idx_nxt  = r_note_idx + 3'd1;
          w_beep_nxt = (w_next_hp != 18'd0);
        end else begin
          w_idx_nxt  = 3'd0;
          w_beep_nxt = (w_first_hp != 18'd0);
        end
      end
    endcase
  end

  // Datapath registers; previous-gamemode resets to game over so a reset
  // released while already in 2'b11 does not start the jingle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gm_prev  <= 2'b11;
      r_beep     <= 1'b0;
      r_busy     <= 1'b0;
      r_note_idx <= 3'd0;
      r_dur_cnt  <= 32'd0;
      r_hp_cnt   <= 18'd0;
    end else begin
      r_gm_prev  <= gamemode;
      r_beep     <= w_beep_nxt;
      r_busy     <= w_busy_nxt;
      r_note_idx <= w_idx_nxt;
      r_dur_cnt  <= w_dur_nxt;
      r_hp_cnt   <= w_hp_nxt;
    end
  end

  assign beep        = r_beep;
  assign busy        = r_busy;
  assign note_idx    = r_note_idx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_beep_melody_seq.sv
// Bench for beep_melody_seq: stimulus pushes the expected per-edge
// {beep, busy, note_idx, state} into a queue; a monitor pops and compares.
module tb_beep_melody_seq;

  localparam int BEAT  = 16;
  localparam int GAP_A = 4;
  localparam int GAP_B = 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [6:0] EXP_IDLE = 7'b0;
  // Hand-computed: ROM half-periods >> 14, and beats per entry.
  localparam int HP_TAB [8] = '{3, 4, 5, 0, 9, 7, 11, 11};
  localparam int BT_TAB [8] = '{1, 1, 1, 1, 2, 2, 2, 4};

  // clock / reset block
  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] gm_a, gm_b;
  logic       beep_a, busy_a, beep_b, busy_b;
  logic [2:0] idx_a, idx_b;
  logic [1:0] st_a, st_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beep_melody_seq #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP_A), .HP_SHIFT(14)) dut_a (
    .clk(clk), .rst(rst_a), .gamemode(gm_a),
    .beep(beep_a), .busy(busy_a), .note_idx(idx_a), .o_dbg_state(st_a)
  );

  beep_melody_seq #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP_B), .HP_SHIFT(14)) dut_b (
    .clk(clk), .rst(rst_b), .gamemode(gm_b),
    .beep(beep_b), .busy(busy_b), .note_idx(idx_b), .o_dbg_state(st_b)
  );

  // scoreboard
  logic [6:0] exp_q_a[$];
  logic [6:0] exp_q_b[$];
  int         tag_q_a[$];
  int         tag_q_b[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_busy_b = 0;
  int         cyc = 0;

  // Expected outputs k edges after the triggering edge (k = 0 is that edge),
  // derived from the note table timeline.
  function automatic logic [6:0] exp_at(input int k, input int gap);
    int t;
    int len;
    logic b;
    t = k;
    for (int i = 0; i < 8; i++) begin
      len = BT_TAB[i] * BEAT;
      if (t < len) begin
        b = (HP_TAB[i] == 0) ? 1'b0 : (((t / HP_TAB[i]) % 2) == 0);
        return {b, 1'b1, 3'(i), ST_PLAY};
      end
      t = t - len;
      if (t < gap) return {1'b0, 1'b1, 3'(i), ST_GAP};
      t = t - gap;
    end
    return {1'b0, 1'b0, 3'd7, ST_DONE};
  endfunction

  // driver tasks: drive inputs for the next edge, queue what it must produce
  task automatic step_a(input logic [1:0] gm, input logic r, input logic [6:0] e, input int tag);
    gm_a  = gm;
    rst_a = r;
    exp_q_a.push_back(e);
    tag_q_a.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic step_b(input logic [1:0] gm, input logic r, input logic [6:0] e, input int tag);
    gm_b  = gm;
    rst_b = r;
    exp_q_b.push_back(e);
    tag_q_b.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_a(input logic [1:0] gm, input logic r, input int n, input int tag);
    for (int i = 0; i < n; i++) step_a(gm, r, EXP_IDLE, tag);
  endtask

  task automatic jingle_a(input int n, input int tag);
    for (int k = 0; k < n; k++) step_a(2'b11, 1'b0, exp_at(k, GAP_A), tag);
  endtask

  // monitor: compares one queued expectation per edge, 1 time unit after it
  logic [6:0] mon_e;
  int         mon_t;
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q_a.size() != 0) begin
      mon_e = exp_q_a.pop_front();
      mon_t = tag_q_a.pop_front();
      n_cmp++;
      if ({beep_a, busy_a, idx_a, st_a} !== mon_e) begin
        n_fail++;
        $display("FAIL dut_a phase=%0d cyc=%0d got beep/busy/idx/st=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 mon_t, cyc, beep_a, busy_a, idx_a, st_a,
                 mon_e[6], mon_e[5], mon_e[4:2], mon_e[1:0]);
      end
    end
    if (exp_q_b.size() != 0) begin
      mon_e = exp_q_b.pop_front();
      mon_t = tag_q_b.pop_front();
      n_cmp++;
      if (busy_b === 1'b1) n_busy_b++;
      if ({beep_b, busy_b, idx_b, st_b} !== mon_e) begin
        n_fail++;
        $display("FAIL dut_b phase=%0d cyc=%0d got beep/busy/idx/st=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 mon_t, cyc, beep_b, busy_b, idx_b, st_b,
                 mon_e[6], mon_e[5], mon_e[4:2], mon_e[1:0]);
      end
    end
  end

  // stimulus
  initial begin
    rst_b = 1'b1;
    gm_b  = 2'b00;
    // 1: reset state
    idle_a(2'b00, 1'b1, 2, 1);
    idle_a(2'b01, 1'b0, 3, 1);
    // 2: full jingle, then held in 11 for 600 edges: one jingle, silent DONE
    jingle_a(600, 2);
    // 3: leave game over -> IDLE, return -> restart one edge later, abort in note 2
    step_a(2'b00, 1'b0, EXP_IDLE, 3);
    jingle_a(45, 3);
    idle_a(2'b10, 1'b0, 3, 4);
    // 4: return to 11 restarts at note 0; reset at jingle cycle 100
    jingle_a(100, 5);
    step_a(2'b11, 1'b1, EXP_IDLE, 6);
    idle_a(2'b11, 1'b0, 50, 6);
    step_a(2'b00, 1'b0, EXP_IDLE, 7);
    jingle_a(21, 7);
    step_a(2'b01, 1'b0, EXP_IDLE, 7);
    // 5: reset released while already in game over: no jingle
    idle_a(2'b11, 1'b1, 2, 8);
    idle_a(2'b11, 1'b0, 300, 8);
    gm_a = 2'b01;
    // 6: one-cycle gaps on the second instance
    step_b(2'b01, 1'b0, EXP_IDLE, 9);
    step_b(2'b01, 1'b0, EXP_IDLE, 9);
    for (int k = 0; k < 240; k++) step_b(2'b11, 1'b0, exp_at(k, GAP_B), 10);
    step_b(2'b00, 1'b0, EXP_IDLE, 10);
    @(posedge clk);
    #3;
    n_cmp++;
    if (n_busy_b != 232) begin
      n_fail++;
      $display("FAIL busy_len_gap1 got %0d cycles want 232", n_busy_b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
